ram8: RTL
=========

Name: ram8

Overview:
- Eight-word by 16-bit storage array. It is the upstream stage feeding the 8-way 16-bit read multiplexer.
- Eight 16-bit registers are written via `load`/`address`; the eight register outputs are selected onto `out` by the existing 8-way mux.
- Adds a sequential bulk-clear sweep (one word per cycle, `busy` flag) so the CPU/memory map can zero the array without eight explicit writes.

Parameters:
- WIDTH, 16, data word width (fixed by the mux it feeds; not to be overridden).
- DEPTH, 8, number of words (fixed; must equal the mux fan-in).
- ADDR_W, 3, address width = log2(DEPTH).

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in  input  16  write data.
- load  input  1  write enable for word `address`.
- address  input  3  word select for both write and read.
- clear  input  1  request to zero all eight words (one-cycle pulse or level).
- out  output  16  contents of word `address`.
- busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Reset: on a rising clk with rst_n=0, all eight words become 16'h0000, state=IDLE, sweep pointer=0, busy=0. Consequently `out`=16'h0000 after the reset edge. Reset overrides load and clear in the same cycle.
- Read path: `out` = word[address] combinationally, with zero-cycle latency, selected by the 8-way mux.
  - A write is visible on `out` after the write edge, not in the same cycle (no write-through bypass).
- Write, state IDLE: load=1 at a rising edge writes `in` to word[address]; all other words hold.
- States:
  - IDLE: busy=0.
    - clear=1 -> SWEEP with pointer=0. A load asserted in the same cycle is dropped; clear has priority.
  - SWEEP: busy=1. Each edge writes 16'h0000 to word[pointer] and increments pointer.
    - At pointer=7 the edge clears word 7, returns to IDLE, and sets pointer to 0.
    - The sweep takes exactly 8 cycles; busy rises the edge after clear is sampled and falls after the 8th sweep edge.
- During SWEEP:
  - load is ignored; no write occurs and no queueing.
  - clear is ignored; no restart.
  - `out` still tracks word[address] and shows zeros as words are swept.
- clear held high continuously: a new sweep starts on the first IDLE edge after the previous sweep ends, i.e. back-to-back sweeps with one IDLE cycle between them.
- Pointer is 3 bits and wraps 7->0 naturally; no value outside 0..7 is possible.
- Reset mid-sweep: the sweep is aborted and all words are zeroed by reset itself; IDLE, busy=0 on the next cycle.
- No X on any output after the first reset edge.

Decomposition:
- Shared package/include holds:
  - constants WIDTH=16, DEPTH=8, ADDR_W=3;
  - state encoding IDLE=1'b0, SWEEP=1'b1.
- Sub-modules:
  - register16: one 16-bit register with load and synchronous active-low reset; instantiated eight times.
  - Read selection reuses the existing 8-way 16-bit mux (no new mux).
  - Load decode (address -> eight per-word enables) is done inline with the sweep-write override.

Test Plan:
- Reset: drive rst_n=0 for one edge after random writes -> `out`=0000 for addresses 0..7, busy=0.
- Write/read: load in=16'hA5A5 at addr 3, then 16'h1234 at addr 7 -> addr3 reads A5A5, addr7 reads 1234, addr0 reads 0000. The value appears only after the write edge.
- Clear sweep: fill words 0..7 with 16'h1111*k (k=1..8), pulse clear -> busy high for exactly 8 cycles. With address=5, `out` holds 6666 until the 6th sweep edge, then 0000. After the sweep all words read 0000.
- Ignored ops: during SWEEP assert load in=16'hBEEF addr 2, and pulse clear again -> word 2 ends at 0000, sweep length still 8, busy falls on schedule.
- Priority: in IDLE assert clear=1 and load=1 (in=16'hCAFE, addr 1) on the same edge -> sweep starts, word 1 never holds CAFE.
- Reset mid-sweep: rst_n=0 at sweep cycle 4 -> next cycle busy=0, all words 0000. A subsequent load of 16'h0F0F at addr 6 succeeds immediately.

Source files
------------

// File: rtl/ram8_pkg.sv
// ram8_pkg: shared constants and state encoding for the ram8 storage array.
//   WIDTH  - data word width, fixed by the 8-way 16-bit read mux.
//   DEPTH  - number of words, equal to the mux fan-in.
//   ADDR_W - word address width, log2(DEPTH).
//   state_e - controller states: IDLE (normal access) or SWEEP (bulk clear).
package ram8_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/ram8_if.sv
// ram8_if: bus bundle between a requester (master) and the ram8 array (slave).
//   in        - write data.
//   load      - write enable for word `address` (honoured only in IDLE).
//   address   - word select for both write and read.
//   clear     - request to zero all words (pulse or level).
//   out       - contents of word `address`, combinational.
//   busy      - high while a clear sweep is in progress.
//   dbg_state - controller state, for observation only.
//   dbg_ptr   - sweep pointer, for observation only.
// Handshake: there is no valid/ready pair. A load is accepted on any rising
// edge where busy=0 and clear=0; it is silently dropped otherwise. A clear is
// accepted on any rising edge where busy=0; busy then stays high for exactly
// eight cycles and clears made while busy are ignored.
interface ram8_if;
  import ram8_pkg::*;

  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic              clear;
  logic [WIDTH-1:0]  out;
  logic              busy;
  state_e            dbg_state;
  logic [ADDR_W-1:0] dbg_ptr;

  modport master (
    output in, load, address, clear,
    input  out, busy, dbg_state, dbg_ptr
  );

  modport slave (
    input  in, load, address, clear,
    output out, busy, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/ram8_register16.sv
// ram8_register16: one 16-bit storage word with load enable and synchronous
// active-low reset.
//   i_clk   - rising-edge clock.
//   i_rst_n - synchronous active-low reset, clears the word to zero.
//   i_load  - capture i_d on the next rising edge.
//   i_d     - data to capture.
//   o_q     - stored word.
module ram8_register16
  import ram8_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ram8.sv
// ram8: eight-word by 16-bit storage array with a sequential bulk clear.
//   clk   - rising-edge clock.
//   rst_n - synchronous active-low reset; zeroes every word and aborts a sweep.
//   bus   - ram8_if slave: in/load/address/clear requests, out/busy results,
//           plus dbg_state/dbg_ptr for observing the controller.
// In IDLE a load writes `in` to word[address]. A clear moves to SWEEP, which
// zeroes one word per cycle from word 0 to word 7 and then returns to IDLE.
// Reads are combinational: out = word[address], with no write-through bypass.
module ram8
  import ram8_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ram8_if.slave bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;

  logic [DEPTH-1:0]  w_we;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_q [DEPTH];

  // State and sweep pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Next-state logic plus the per-word write decode. In SWEEP the sweep
  // pointer owns the write port and user loads/clears are ignored; in IDLE
  // a clear wins over a load in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_we         = '0;
    w_wdata      = bus.in;

    case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_state_next = SWEEP;
          w_ptr_next   = '0;
        end else if (bus.load) begin
          w_we[bus.address] = 1'b1;
        end
      end
      SWEEP: begin
        w_we[r_ptr] = 1'b1;
        w_wdata     = '0;
        // The 3-bit pointer wraps 7->0 on its own, so leaving SWEEP at 7
        // also leaves the pointer at 0 for the next sweep.
        w_ptr_next  = r_ptr + ADDR_W'(1);
        if (r_ptr == ADDR_W'(DEPTH - 1)) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    ram8_register16 u_reg (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_load  (w_we[g]),
      .i_d     (w_wdata),
      .o_q     (w_q[g])
    );
  end

  // 8-way 16-bit read select.
  assign bus.out       = w_q[bus.address];
  assign bus.busy      = (r_state == SWEEP);
  assign bus.dbg_state = r_state;
  assign bus.dbg_ptr   = r_ptr;

endmodule
